pixel_scan_ctrl: RTL

//  Parametrised display-scan controller for multiplexed 7-segment/pixel banks. Replaces the

---
 rtl/pixel_scan_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pixel_scan_ctrl.sv
// pixel_scan_ctrl: multiplexed display scan controller with an integrated slot
// timer, per-digit enable mask with skip, anti-ghost blanking at every slot
// start and a frame-start strobe.
// Optional feature macro: PIXEL_DIMMING_EN adds a 4-bit brightness input that
// shortens the anode-on window inside each slot without changing slot length.
module pixel_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SEL_W        = 3,
  parameter int DIV_COUNT    = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_mask,
`ifdef PIXEL_DIMMING_EN
  input  logic [3:0]            brightness,
`endif
  output logic [NUM_DIGITS-1:0] a,
  output logic [SEL_W-1:0]      seq_sel,
  output logic                  frame_start
);

  localparam int CNT_W = $clog2(DIV_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] a_q, a_d;
  logic                  fs_q, fs_d;
  logic [SEL_W:0]        nxt;
  logic                  on_window;

  // Lowest enabled digit index (0 when the mask is empty).
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_DIGITS-1:0] m);
    lowest_set = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  // Next enabled digit above cur; MSB flags a wrap back to the lowest digit,
  // which is where a new frame begins.
  function automatic logic [SEL_W:0] next_enabled(input logic [NUM_DIGITS-1:0] m,
                                                  input logic [SEL_W-1:0]      cur);
    logic             found;
    logic [SEL_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) begin
        found = 1'b1;
        idx   = SEL_W'(i);
      end
    end
    if (found) next_enabled = {1'b0, idx};
    else       next_enabled = {1'b1, lowest_set(m)};
  endfunction

`ifdef PIXEL_DIMMING_EN
  localparam int ON_UNIT = (DIV_COUNT - BLANK_CYCLES) >> 4;

  logic [3:0] bright_q;
  logic [3:0] bright_eff;
  int         on_end;

  // Brightness is captured once per slot, on its first cycle.
  always_ff @(posedge clk) begin
    if (state_q == S_BLANK && cnt_q == '0) bright_q <= brightness;
  end

  // The first-cycle value is used directly so short blanking never sees a stale level.
  always_comb begin
    bright_eff = (state_q == S_BLANK && cnt_q == '0) ? brightness : bright_q;
    on_end     = BLANK_CYCLES + ON_UNIT * (int'(bright_eff) + 1);
    on_window  = (int'(cnt_d) < on_end);
  end
`else
  // Without dimming the anode is driven for the entire ON phase.
  always_comb on_window = 1'b1;
`endif

  // Next-state logic: slot timer, digit advance with skip, and registered anode pattern.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    fs_d    = 1'b0;
    nxt     = next_enabled(digit_mask, sel_q);
    case (state_q)
      S_IDLE: begin
        if (enable && (digit_mask != '0)) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          sel_d   = lowest_set(digit_mask);
          fs_d    = 1'b1;
        end
      end
      default: begin
        if (!enable || (digit_mask == '0)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          sel_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          sel_d   = nxt[SEL_W-1:0];
          fs_d    = nxt[SEL_W];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = S_ON;
        end
      end
    endcase

    // At most one anode low, only in ON, and only while its mask bit is still set.
    a_d = '1;
    if (state_d == S_ON && on_window) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((SEL_W'(i) == sel_d) && digit_mask[i]) a_d[i] = 1'b0;
      end
    end
  end

  // State and output registers; outputs come straight from next-state so they stay coherent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      a_q     <= '1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      fs_q    <= fs_d;
    end
  end

  assign a           = a_q;
  assign seq_sel     = sel_q;
  assign frame_start = fs_q;

endmodule
